// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_pkg
// Description : Shared definitions for the instruction sequencer. Holds the
//               FSM state encoding, the NOP instruction word and the default
//               widths that match simple_cpu.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 4;

  // Hold counter width; covers the full 1..255 hold range.
  localparam int HOLD_CNT_BITS   = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [DEF_INSTR_WIDTH-1:0] NOP_INSTR = '0;

endpackage : cpu_seq_pkg
`default_nettype wire

// File: rtl/seq_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : seq_prog_mem
// Description : Programme store for the sequencer. 2^ADDR_BITS x WIDTH,
//               synchronous write, asynchronous read, contents not reset.
// Ports       : clk     - system clock, rising edge
//               wr_en   - write strobe
//               wr_addr - write address
//               wr_data - write data
//               rd_addr - read address
//               rd_data - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module seq_prog_mem #(
  parameter int WIDTH     = 20,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : seq_prog_mem
`default_nettype wire

// File: rtl/cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_instr_sequencer
// Description : Replays a programme held in a small internal memory onto the
//               simple_cpu instruction bus, presenting each word for
//               HOLD_CYCLES clocks, then pulses done.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous reset, active low
//               load_en     - programme memory write strobe (ignored in RUN)
//               load_addr   - programme memory write address
//               load_data   - programme memory write data
//               prog_len    - number of words to run, sampled on start
//               start       - begin execution
//               abort       - stop execution immediately
//               instruction - instruction to simple_cpu
//               instr_valid - a programme word is being presented
//               pc          - index of the word currently presented
//               busy        - high while running
//               done        - one-cycle pulse after the last word's hold
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = DEF_PC_BITS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  localparam int                       DEPTH     = 1 << PC_BITS;
  localparam logic [PC_BITS:0]         MAX_LEN   = (PC_BITS+1)'(DEPTH);
  localparam logic [PC_BITS:0]         LEN_ONE   = (PC_BITS+1)'(1);
  localparam logic [PC_BITS-1:0]       PC_ONE    = PC_BITS'(1);
  localparam logic [HOLD_CNT_BITS-1:0] HOLD_LAST = HOLD_CNT_BITS'(HOLD_CYCLES - 1);
  localparam logic [HOLD_CNT_BITS-1:0] HOLD_ONE  = HOLD_CNT_BITS'(1);
  localparam logic [INSTR_WIDTH-1:0]   NOP       = INSTR_WIDTH'(NOP_INSTR);

  logic [1:0]               state;
  logic [HOLD_CNT_BITS-1:0] hold_cnt;
  logic [PC_BITS:0]         len;

  logic                     mem_wr_en;
  logic [PC_BITS-1:0]       mem_rd_addr;
  logic [INSTR_WIDTH-1:0]   mem_rd_data;
  logic [INSTR_WIDTH-1:0]   first_word;
  logic [PC_BITS:0]         start_len;
  logic                     accept_start;
  logic                     hold_done;
  logic                     last_word;

  // The memory is frozen while a programme runs.
  assign mem_wr_en = load_en && (state != ST_RUN);

  // The read port always looks one word ahead of what is presented, so the
  // next word is ready the moment the current hold expires. Outside RUN it
  // points at word 0, the word issued on start.
  assign mem_rd_addr = (state == ST_RUN) ? (pc + PC_ONE) : '0;

  seq_prog_mem #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (PC_BITS)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  // A write to word 0 in the same cycle as start is forwarded so the freshly
  // loaded word is the one issued.
  assign first_word = (load_en && (load_addr == '0)) ? load_data : mem_rd_data;

  assign start_len    = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign accept_start = (state == ST_IDLE) && start && !abort;
  assign hold_done    = (hold_cnt == HOLD_LAST);
  assign last_word    = ({1'b0, pc} == (len - LEN_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      instruction <= NOP;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hold_cnt    <= '0;
      len         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept_start) begin
            len      <= start_len;
            pc       <= '0;
            hold_cnt <= '0;
            if (start_len == '0) begin
              // Empty programme: skip straight to the done pulse.
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state       <= ST_RUN;
              instruction <= first_word;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (abort) begin
            state       <= ST_IDLE;
            instruction <= NOP;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hold_cnt    <= '0;
          end else if (hold_done) begin
            hold_cnt <= '0;
            if (last_word) begin
              state       <= ST_FINISH;
              instruction <= NOP;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              pc          <= pc + PC_ONE;
              instruction <= mem_rd_data;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end

        ST_FINISH: begin
          // done was raised on entry; it drops as we return to IDLE whether
          // or not abort is asserted.
          state <= ST_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          instruction <= NOP;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

endmodule : cpu_instr_sequencer
`default_nettype wire

// File: tb/tb_cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_instr_sequencer
// Description : Self-checking bench for cpu_instr_sequencer. Expected
//               (instruction, pc) pairs are queued for every presented clock
//               when a run is started and popped as the DUT presents words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_instr_sequencer;

  localparam int IW    = 20;
  localparam int PB    = 4;
  localparam int HOLD  = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [PB-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [PB:0]   prog_len;
  logic          start;
  logic          abort;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          busy;
  logic          done;

  cpu_instr_sequencer #(
    .INSTR_WIDTH (IW),
    .PC_BITS     (PB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PB-1:0] pc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [IW-1:0] model_mem [DEPTH];
  int            total;
  int            bad;
  int            done_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every presented clock must match the head entry.
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_seen++;
      if (instr_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_word", {31'b0, instr_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_instr", {12'b0, instruction}, {12'b0, mon_e.instr});
          chk("sb_pc", {28'b0, pc}, {28'b0, mon_e.pc});
          chk("sb_busy", {31'b0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic load_word(input int a, input logic [IW-1:0] d);
    @(posedge clk); #1;
    load_en   = 1'b1;
    load_addr = PB'(a);
    load_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic push_prog(input int n);
    for (int i = 0; i < n; i++)
      for (int h = 0; h < HOLD; h++)
        sb.push_back('{instr: model_mem[i], pc: PB'(i)});
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_instr"}, {12'b0, instruction}, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy},        32'd0);
    chk({tag, "_done"},  {31'b0, done},        32'd0);
  endtask

  // Runs a programme of plen words. inject: mid-run write to mem[1] plus a
  // second start, both of which must be ignored. wf: write word 0 in the
  // same cycle as start.
  task automatic run_prog(input int plen, input bit inject, input bit wf,
                          input logic [IW-1:0] wf_data);
    int eff;
    int n;
    int base_done;
    eff = (plen > DEPTH) ? DEPTH : plen;
    @(posedge clk); #1;
    if (wf) begin
      load_en   = 1'b1;
      load_addr = '0;
      load_data = wf_data;
      model_mem[0] = wf_data;
    end
    push_prog(eff);
    prog_len  = (PB+1)'(plen);
    start     = 1'b1;
    base_done = done_seen;
    @(posedge clk); #1;
    start   = 1'b0;
    load_en = 1'b0;
    for (n = 0; n < eff * HOLD + 20; n++) begin
      @(negedge clk);
      if (inject && n == 2) begin
        load_en   = 1'b1;
        load_addr = PB'(1);
        load_data = 20'hFFFFF;
        start     = 1'b1;
      end
      if (inject && n == 3) begin
        load_en = 1'b0;
        start   = 1'b0;
      end
      if (done) break;
    end
    chk("done_latency", n, eff * HOLD);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check_idle("post_done");
    chk("final_pc", {28'b0, pc}, (eff == 0) ? 32'd0 : 32'(eff - 1));
    chk("sb_drained", sb.size(), 32'd0);
    chk("done_pulses", done_seen - base_done, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    total = 0; bad = 0; done_seen = 0;
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset state, while held and after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    chk("in_reset_pc", {28'b0, pc}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_reset");
    chk("after_reset_pc", {28'b0, pc}, 32'd0);

    // Basic 3-word programme; first fill the rest of memory with zeros.
    for (int i = 3; i < DEPTH; i++) load_word(i, '0);
    load_word(0, 20'h47000);
    load_word(1, 20'h53000);
    load_word(2, 20'h72001);
    run_prog(3, 1'b0, 1'b0, '0);

    // Empty programme.
    run_prog(0, 1'b0, 1'b0, '0);

    // Abort during the second word, hold count 2.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      for (int h = 0; h < HOLD; h++)
        if (!(i == 1 && h == HOLD - 1))
          sb.push_back('{instr: model_mem[i], pc: PB'(i)});
    prog_len = 5'd3;
    start    = 1'b1;
    base     = done_seen;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle("after_abort");
    repeat (2 * HOLD) @(negedge clk);
    chk("abort_no_done", done_seen - base, 32'd0);
    chk("abort_sb_drained", sb.size(), 32'd0);

    // Replay from pc=0 after abort.
    run_prog(3, 1'b0, 1'b0, '0);

    // Load and start during RUN are ignored; next run shows mem[1] intact.
    run_prog(3, 1'b1, 1'b0, '0);
    run_prog(3, 1'b0, 1'b0, '0);

    // Write-first: word 0 written in the same cycle as start.
    run_prog(3, 1'b0, 1'b1, 20'h12345);

    // Over-length programme is clamped to the full memory.
    for (int i = 0; i < DEPTH; i++) load_word(i, IW'($urandom));
    run_prog(17, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-run; memory must survive.
    @(posedge clk); #1;
    push_prog(DEPTH);
    prog_len = 5'd16;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_reset");
    chk("async_reset_pc", {28'b0, pc}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_prog(16, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_instr_sequencer
`default_nettype wire
